// File: rtl/pipelined_rca_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_rca_adder
// Purpose  : Pipelined WIDTH-bit ripple-carry adder with carry-in. Each
//            pipeline stage ripples one SEG_WIDTH-bit segment through a chain
//            of full-adder cells. The carry out of each segment is registered
//            and passed to the next stage. Upper operand bits that are still
//            needed travel forward alongside the partial sum, and each stage
//            drops the operand bits it has consumed. Lower sum bits travel
//            forward as well, so the full sum emerges aligned at the last
//            stage.
//
// Parameters:
//   WIDTH      operand / sum width (default 16)
//   SEG_WIDTH  bits rippled per stage (default 4); WIDTH must be a multiple
//   STAGES     derived pipeline depth = WIDTH / SEG_WIDTH
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands present
//   in_ready   out  adder can accept this cycle (= !out_valid | out_ready)
//   a, b       in   WIDTH-bit unsigned operands
//   carry_in   in   carry into bit 0
//   out_valid  out  result present
//   out_ready  in   consumer accepts result
//   sum        out  low WIDTH bits of a + b + carry_in
//   carry_out  out  carry out of bit WIDTH-1
//   overflow   out  signed two's-complement overflow
//                   (only present when RCA_OVERFLOW_EN is defined)
//
// Optional feature macro: RCA_OVERFLOW_EN
//
// Revision : 1.0 - initial pipelined release
// ============================================================================
module pipelined_rca_adder #(
  parameter int WIDTH     = 16,
  parameter int SEG_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef RCA_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int STAGES = WIDTH / SEG_WIDTH;

  // Stop elaboration when the segments do not tile the operand exactly.
  if ((SEG_WIDTH < 1) || ((WIDTH % SEG_WIDTH) != 0)) begin : g_cfg_check
    $fatal(1, "pipelined_rca_adder: WIDTH must be a positive multiple of SEG_WIDTH");
  end

  // A single enable moves the whole pipeline forward. Bubbles shift just like
  // data, so the only reason to stop is a result that is being held at the
  // output. in_ready depends on nothing except the output handshake.
  logic adv_en;

  assign adv_en   = !out_valid || out_ready;
  assign in_ready = adv_en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage k owns sum bits [HI-1:LO]. After it has run, the operand bits
    // [WIDTH-1:HI] (REM of them) are the only ones still needed downstream.
    localparam int LO  = k * SEG_WIDTH;
    localparam int HI  = LO + SEG_WIDTH;
    localparam int REM = WIDTH - HI;

    logic                 valid_d;
    logic                 seg_cin;
    logic [SEG_WIDTH-1:0] seg_a;
    logic [SEG_WIDTH-1:0] seg_b;
    logic [SEG_WIDTH-1:0] seg_sum;
    logic                 seg_cout;
    logic [HI-1:0]        sum_d;

    logic                 valid_q;
    logic                 carry_q;
    logic [HI-1:0]        sum_q;

    if (k == 0) begin : g_first
      assign valid_d = in_valid;
      assign seg_cin = carry_in;
      assign seg_a   = a[SEG_WIDTH-1:0];
      assign seg_b   = b[SEG_WIDTH-1:0];
      assign sum_d   = seg_sum;
    end else begin : g_next
      // The previous stage always forwards at least this segment's operand
      // bits, so its g_fwd block exists whenever k > 0.
      assign valid_d = g_stage[k-1].valid_q;
      assign seg_cin = g_stage[k-1].carry_q;
      assign seg_a   = g_stage[k-1].g_fwd.opa_q[SEG_WIDTH-1:0];
      assign seg_b   = g_stage[k-1].g_fwd.opb_q[SEG_WIDTH-1:0];
      // Lower sum bits already computed are delayed one stage to stay
      // aligned with the segment produced here.
      assign sum_d   = {seg_sum, g_stage[k-1].sum_q};
    end

    // Ripple chain of full-adder cells: s = a^b^c, c' = ab | c(a^b).
    always_comb begin
      logic c;
      c       = seg_cin;
      seg_sum = '0;
      for (int i = 0; i < SEG_WIDTH; i++) begin
        seg_sum[i] = seg_a[i] ^ seg_b[i] ^ c;
        c          = (seg_a[i] & seg_b[i]) | (c & (seg_a[i] ^ seg_b[i]));
      end
      seg_cout = c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv_en) begin
        valid_q <= valid_d;
        carry_q <= seg_cout;
        sum_q   <= sum_d;
      end
    end

    // Forward only the operand bits that later stages still need.
    if (REM > 0) begin : g_fwd
      logic [REM-1:0] opa_d;
      logic [REM-1:0] opb_d;
      logic [REM-1:0] opa_q;
      logic [REM-1:0] opb_q;

      if (k == 0) begin : g_src_in
        assign opa_d = a[WIDTH-1:HI];
        assign opb_d = b[WIDTH-1:HI];
      end else begin : g_src_prev
        assign opa_d = g_stage[k-1].g_fwd.opa_q[REM+SEG_WIDTH-1:SEG_WIDTH];
        assign opb_d = g_stage[k-1].g_fwd.opb_q[REM+SEG_WIDTH-1:SEG_WIDTH];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (adv_en) begin
          opa_q <= opa_d;
          opb_q <= opb_d;
        end
      end
    end

`ifdef RCA_OVERFLOW_EN
    // Signed overflow is the carry into the MSB XOR the carry out of it.
    // The carry into the MSB is recovered from the top full-adder cell as
    // a ^ b ^ s, so the ripple loop does not need an extra output.
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_d;
      logic ovf_q;

      assign ovf_d = seg_a[SEG_WIDTH-1] ^ seg_b[SEG_WIDTH-1] ^
                     seg_sum[SEG_WIDTH-1] ^ seg_cout;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv_en) begin
          ovf_q <= ovf_d;
        end
      end
    end
`endif
  end

  // Outputs come straight from the final stage registers.
  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign carry_out = g_stage[STAGES-1].carry_q;
`ifdef RCA_OVERFLOW_EN
  assign overflow  = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_rca_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_rca_adder
// Purpose  : Directed self-checking bench for pipelined_rca_adder. It drives
//            three instances: 16/4 (main), 8/8 (single stage) and 32/4
//            (eight stages). It checks reset, latency, wrap, streaming,
//            backpressure, mid-flight reset and the corner vectors for each
//            width. It also checks overflow when RCA_OVERFLOW_EN is defined.
// Revision : 1.0
// ============================================================================
module tb_pipelined_rca_adder;

  logic clk;
  logic rst_n;

  // 16-bit / 4-bit segments
  logic        v16, rdy16, c16, irdy16, vld16, co16;
  logic [15:0] a16, b16, s16;
  // 8-bit / 8-bit segments
  logic        v8, rdy8, c8, irdy8, vld8, co8;
  logic [7:0]  a8, b8, s8;
  // 32-bit / 4-bit segments
  logic        v32, rdy32, c32, irdy32, vld32, co32;
  logic [31:0] a32, b32, s32;
`ifdef RCA_OVERFLOW_EN
  logic        ov16, ov8, ov32;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  pipelined_rca_adder #(.WIDTH(16), .SEG_WIDTH(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(irdy16),
    .a(a16), .b(b16), .carry_in(c16), .out_valid(vld16),
    .out_ready(rdy16), .sum(s16), .carry_out(co16)
`ifdef RCA_OVERFLOW_EN
    , .overflow(ov16)
`endif
  );

  pipelined_rca_adder #(.WIDTH(8), .SEG_WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(irdy8),
    .a(a8), .b(b8), .carry_in(c8), .out_valid(vld8),
    .out_ready(rdy8), .sum(s8), .carry_out(co8)
`ifdef RCA_OVERFLOW_EN
    , .overflow(ov8)
`endif
  );

  pipelined_rca_adder #(.WIDTH(32), .SEG_WIDTH(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(irdy32),
    .a(a32), .b(b32), .carry_in(c32), .out_valid(vld32),
    .out_ready(rdy32), .sum(s32), .carry_out(co32)
`ifdef RCA_OVERFLOW_EN
    , .overflow(ov32)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated 16-bit transaction: four-cycle latency, then one result.
  task automatic single16(input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic [16:0] exp, input string tag);
`ifdef RCA_OVERFLOW_EN
    logic exp_ovf;
    exp_ovf = (ta[15] == tb[15]) && (exp[15] != ta[15]);
`endif
    rdy16 = 1'b1;
    check({tag, " in_ready"}, 64'(irdy16), 64'(1));
    v16 = 1'b1; a16 = ta; b16 = tb; c16 = tc;
    tick();
    v16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check({tag, " early valid"}, 64'(vld16), 64'(0));
      check({tag, " in_ready"}, 64'(irdy16), 64'(1));
      tick();
    end
    check({tag, " valid"}, 64'(vld16), 64'(1));
    check({tag, " result"}, 64'({co16, s16}), 64'(exp));
`ifdef RCA_OVERFLOW_EN
    check({tag, " overflow"}, 64'(ov16), 64'(exp_ovf));
`endif
    tick();
    check({tag, " drained"}, 64'(vld16), 64'(0));
  endtask

  // Stream n random vectors back to back. out_ready is low for loop cycles
  // st_lo..st_hi; pass negative bounds for no stall.
  task automatic stream16(input int n, input int st_lo, input int st_hi, input string tag);
    logic [15:0] va[$];
    logic [15:0] vb[$];
    logic        vc[$];
    logic [16:0] ex[$];
    logic [16:0] hval;
    logic        held;
    logic        accept;
    int sent, got, first, last;
    sent = 0; got = 0; first = -1; last = -1; held = 1'b0; hval = '0;
    for (int i = 0; i < n; i++) begin
      logic [15:0] ta, tb;
      logic tc;
      ta = 16'($urandom); tb = 16'($urandom); tc = 1'($urandom);
      va.push_back(ta); vb.push_back(tb); vc.push_back(tc);
      ex.push_back(17'(ta) + 17'(tb) + 17'(tc));
    end
    for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
      rdy16 = !(cyc >= st_lo && cyc <= st_hi);
      #1;
      check({tag, " in_ready"}, 64'(irdy16), 64'(!vld16 || rdy16));
      if (held) begin
        check({tag, " hold valid"}, 64'(vld16), 64'(1));
        check({tag, " hold data"}, 64'({co16, s16}), 64'(hval));
      end
      held = vld16 && !rdy16;
      hval = {co16, s16};
      if (vld16 && rdy16) begin
        check({tag, " result"}, 64'({co16, s16}), 64'(ex[got]));
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (sent < n) begin
        v16 = 1'b1; a16 = va[sent]; b16 = vb[sent]; c16 = vc[sent];
      end else begin
        v16 = 1'b0;
      end
      accept = v16 && irdy16;
      tick();
      if (accept) sent++;
    end
    v16 = 1'b0;
    rdy16 = 1'b1;
    check({tag, " count"}, 64'(got), 64'(n));
    check({tag, " no extra"}, 64'(vld16), 64'(0));
    if (st_lo < 0) check({tag, " one per cycle"}, 64'(last - first), 64'(n - 1));
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic [8:0] exp);
    check("d8 idle", 64'(vld8), 64'(0));
    v8 = 1'b1; a8 = ta; b8 = tb; c8 = tc;
    tick();
    v8 = 1'b0;
    check("d8 valid", 64'(vld8), 64'(1));
    check("d8 result", 64'({co8, s8}), 64'(exp));
    tick();
  endtask

  task automatic run32(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                       input logic [32:0] exp);
    v32 = 1'b1; a32 = ta; b32 = tb; c32 = tc;
    tick();
    v32 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("d32 early valid", 64'(vld32), 64'(0));
      tick();
    end
    check("d32 valid", 64'(vld32), 64'(1));
    check("d32 result", 64'({co32, s32}), 64'(exp));
    tick();
    check("d32 drained", 64'(vld32), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    v16 = 0; a16 = '0; b16 = '0; c16 = 0; rdy16 = 1;
    v8  = 0; a8  = '0; b8  = '0; c8  = 0; rdy8  = 1;
    v32 = 0; a32 = '0; b32 = '0; c32 = 0; rdy32 = 1;
    #2;
    // Asynchronous reset is visible before any clock edge.
    check("reset valid", 64'(vld16), 64'(0));
    check("reset sum", 64'(s16), 64'(0));
    check("reset carry", 64'(co16), 64'(0));
    check("reset d8 valid", 64'(vld8), 64'(0));
    check("reset d32 valid", 64'(vld32), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("post-reset in_ready", 64'(irdy16), 64'(1));

    // Latency and directed sums
    single16(16'h1234, 16'h1111, 1'b0, 17'h0_2345, "basic");
    single16(16'hFFFF, 16'h0000, 1'b1, 17'h1_0000, "wrap");
    single16(16'hAAAA, 16'h5555, 1'b1, 17'h1_0000, "alt ripple");
    single16(16'h8000, 16'h8000, 1'b0, 17'h1_0000, "msb carry");
    single16(16'h00FF, 16'h0001, 1'b0, 17'h0_0100, "seg carry");
    single16(16'h7FFF, 16'h0001, 1'b0, 17'h0_8000, "signed ovf");

    // Streaming and backpressure
    stream16(20, -1, -1, "stream");
    stream16(8, 6, 9, "backpressure");

    // Reset with a result at the output and three more in flight
    rdy16 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v16 = 1'b1; a16 = 16'h1000 + 16'(i); b16 = 16'h0001; c16 = 1'b0;
      tick();
    end
    v16 = 1'b0;
    check("midflight valid before reset", 64'(vld16), 64'(1));
    check("midflight sum before reset", 64'(s16), 64'(16'h1001));
    rst_n = 1'b0;
    #1;
    check("midflight reset valid", 64'(vld16), 64'(0));
    check("midflight reset sum", 64'(s16), 64'(0));
    check("midflight reset carry", 64'(co16), 64'(0));
    tick();
    rst_n = 1'b1;
    rdy16 = 1'b1;
    #1;
    single16(16'h0F0F, 16'h00F1, 1'b1, 17'h0_1001, "after reset");

    // Single-stage 8/8 corners
    run8(8'h00, 8'h00, 1'b0, 9'h000);
    run8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    run8(8'h55, 8'hAA, 1'b0, 9'h0FF);
    run8(8'hAA, 8'hAA, 1'b1, 9'h155);
    run8(8'hFF, 8'h00, 1'b1, 9'h100);

    // Eight-stage 32/4 corners
    run32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000);
    run32(32'h5555_5555, 32'hAAAA_AAAA, 1'b0, 33'h0_FFFF_FFFF);
    run32(32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0, 33'h1_5555_5554);
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
    run32(32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
